// File: rtl/sd_cmd_responder.sv
// SD card-side CMD line responder.
// Receives 48-bit host commands sampled on SD clock rises, checks framing and CRC7,
// then on request drives a short (48-bit) or long (136-bit) response on SD clock falls
// after an NCR gap. Everything runs in clk_i; sd_clk_i is oversampled.
module sd_cmd_responder #(
    parameter int unsigned NCR         = 2,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         sd_clk_i,
    input  logic         sd_cmd_i,
    output logic         sd_cmd_o,
    output logic         sd_cmd_oe,
    output logic         cmd_valid_o,
    output logic         cmd_err_o,
    output logic [5:0]   cmd_idx_o,
    output logic [31:0]  cmd_arg_o,
    input  logic         resp_valid_i,
    input  logic [1:0]   resp_type_i,
    input  logic [5:0]   resp_idx_i,
    input  logic [127:0] resp_data_i,
    output logic         busy_o
);

    typedef enum logic [2:0] {
        StIdle,
        StRx,
        StCheck,
        StWaitResp,
        StGap,
        StTx
    } state_e;

    // CRC7, polynomial x^7 + x^3 + 1, one bit per step, MSB first.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
        logic fb;
        fb = b ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    // ------------------------------------------------------------------
    // Synchronizers and SD clock edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] cmd_sync_q;
    logic                   sd_clk_prev_q;
    logic                   sd_clk_s;
    logic                   sd_cmd_s;
    logic                   rise;
    logic                   fall;

    // Both lines go through equal-depth chains so CMD stays aligned with the clock edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clk_sync_q    <= '1;
            cmd_sync_q    <= '1;
            sd_clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q    <= (clk_sync_q << 1) | SYNC_STAGES'(sd_clk_i);
            cmd_sync_q    <= (cmd_sync_q << 1) | SYNC_STAGES'(sd_cmd_i);
            sd_clk_prev_q <= sd_clk_s;
        end
    end

    assign sd_clk_s = clk_sync_q[SYNC_STAGES-1];
    assign sd_cmd_s = cmd_sync_q[SYNC_STAGES-1];
    assign rise     = sd_clk_s & ~sd_clk_prev_q;
    assign fall     = ~sd_clk_s & sd_clk_prev_q;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e        state_q, state_d;
    logic [47:0]   rx_q, rx_d;
    logic [5:0]    rx_cnt_q, rx_cnt_d;
    logic [6:0]    rx_crc_q, rx_crc_d;
    logic [6:0]    ncr_cnt_q, ncr_cnt_d;
    logic [127:0]  tx_q, tx_d;
    logic          tx_long_q, tx_long_d;
    logic [7:0]    tx_cnt_q, tx_cnt_d;
    logic [6:0]    tx_crc_q, tx_crc_d;
    logic          cmd_o_q, cmd_o_d;
    logic          oe_q, oe_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic          cmd_err_q, cmd_err_d;
    logic [5:0]    cmd_idx_q, cmd_idx_d;
    logic [31:0]   cmd_arg_q, cmd_arg_d;

    logic          frame_ok;
    logic          resp_has_frame;
    logic          tx_step;
    logic [7:0]    tx_plen;
    logic [7:0]    tx_crc_end;

    // Start bit is the first bit shifted in, so it ends at bit 47.
    assign frame_ok       = ~rx_q[47] & rx_q[46] & rx_q[0] & (rx_q[7:1] == rx_crc_q);
    assign resp_has_frame = (resp_type_i == 2'd1) || (resp_type_i == 2'd2);
    // Bits shifted from tx_q before the CRC: 40 for short, 128 for long frames.
    assign tx_plen        = tx_long_q ? 8'd128 : 8'd40;
    assign tx_crc_end     = tx_plen + 8'd7;
    assign tx_step        = fall && ((state_q == StTx) ||
                                     ((state_q == StGap) && (ncr_cnt_q >= 7'(NCR))));

    // State register and all registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            rx_q        <= '0;
            rx_cnt_q    <= '0;
            rx_crc_q    <= '0;
            ncr_cnt_q   <= '0;
            tx_q        <= '0;
            tx_long_q   <= 1'b0;
            tx_cnt_q    <= '0;
            tx_crc_q    <= '0;
            cmd_o_q     <= 1'b1;
            oe_q        <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_err_q   <= 1'b0;
            cmd_idx_q   <= '0;
            cmd_arg_q   <= '0;
        end else begin
            state_q     <= state_d;
            rx_q        <= rx_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_crc_q    <= rx_crc_d;
            ncr_cnt_q   <= ncr_cnt_d;
            tx_q        <= tx_d;
            tx_long_q   <= tx_long_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_crc_q    <= tx_crc_d;
            cmd_o_q     <= cmd_o_d;
            oe_q        <= oe_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_err_q   <= cmd_err_d;
            cmd_idx_q   <= cmd_idx_d;
            cmd_arg_q   <= cmd_arg_d;
        end
    end

    // Next-state logic: receive, check, wait for response, NCR gap, transmit.
    always_comb begin
        state_d     = state_q;
        rx_d        = rx_q;
        rx_cnt_d    = rx_cnt_q;
        rx_crc_d    = rx_crc_q;
        ncr_cnt_d   = ncr_cnt_q;
        tx_d        = tx_q;
        tx_long_d   = tx_long_q;
        tx_cnt_d    = tx_cnt_q;
        tx_crc_d    = tx_crc_q;
        cmd_o_d     = cmd_o_q;
        oe_d        = oe_q;
        cmd_valid_d = 1'b0;
        cmd_err_d   = 1'b0;
        cmd_idx_d   = cmd_idx_q;
        cmd_arg_d   = cmd_arg_q;

        // Rises since the command end bit, saturating at NCR; a late response
        // then goes out on the first fall after it is latched.
        if (rise && (ncr_cnt_q < 7'(NCR))) begin
            ncr_cnt_d = ncr_cnt_q + 7'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (rise && !sd_cmd_s) begin
                    state_d  = StRx;
                    rx_d     = '0;
                    rx_cnt_d = '0;
                    rx_crc_d = '0;
                end
            end
            StRx: begin
                if (rise) begin
                    rx_d = {rx_q[46:0], sd_cmd_s};
                    // CRC covers the first 40 bits; the start bit left it at zero.
                    if (rx_cnt_q < 6'd39) begin
                        rx_crc_d = crc7_step(rx_crc_q, sd_cmd_s);
                    end
                    if (rx_cnt_q == 6'd46) begin
                        state_d   = StCheck;
                        ncr_cnt_d = '0;
                    end else begin
                        rx_cnt_d = rx_cnt_q + 6'd1;
                    end
                end
            end
            StCheck: begin
                if (frame_ok) begin
                    cmd_valid_d = 1'b1;
                    cmd_idx_d   = rx_q[45:40];
                    cmd_arg_d   = rx_q[39:8];
                    state_d     = StWaitResp;
                end else begin
                    cmd_err_d = 1'b1;
                    state_d   = StIdle;
                end
            end
            StWaitResp: begin
                if (resp_valid_i) begin
                    if (resp_has_frame) begin
                        state_d   = StGap;
                        tx_long_d = (resp_type_i == 2'd2);
                        tx_cnt_d  = '0;
                        tx_crc_d  = '0;
                        if (resp_type_i == 2'd2) begin
                            tx_d = {2'b00, 6'h3F, resp_data_i[127:8]};
                        end else begin
                            tx_d = {2'b00, resp_idx_i, resp_data_i[31:0], 88'h0};
                        end
                    end else begin
                        state_d = StIdle;
                    end
                end else if (rise && !sd_cmd_s) begin
                    // Host started a new command; the pending response is dropped.
                    state_d  = StRx;
                    rx_d     = '0;
                    rx_cnt_d = '0;
                    rx_crc_d = '0;
                end
            end
            StGap: begin
                // Leaves through the tx_step path below.
            end
            StTx: begin
                // Driven entirely by tx_step below.
            end
            default: state_d = StIdle;
        endcase

        // One bit per fall: payload, then serial CRC, then end bit, then release.
        if (tx_step) begin
            tx_cnt_d = tx_cnt_q + 8'd1;
            if (tx_cnt_q < tx_plen) begin
                state_d = StTx;
                oe_d    = 1'b1;
                cmd_o_d = tx_q[127];
                tx_d    = {tx_q[126:0], 1'b0};
                // Long-frame CRC skips the 8 header bits.
                if (!tx_long_q || (tx_cnt_q >= 8'd8)) begin
                    tx_crc_d = crc7_step(tx_crc_q, tx_q[127]);
                end
            end else if (tx_cnt_q < tx_crc_end) begin
                cmd_o_d  = tx_crc_q[6];
                tx_crc_d = {tx_crc_q[5:0], 1'b0};
            end else if (tx_cnt_q == tx_crc_end) begin
                cmd_o_d = 1'b1;
            end else begin
                cmd_o_d  = 1'b1;
                oe_d     = 1'b0;
                tx_cnt_d = '0;
                state_d  = StIdle;
            end
        end
    end

    assign sd_cmd_o    = cmd_o_q;
    assign sd_cmd_oe   = oe_q;
    assign cmd_valid_o = cmd_valid_q;
    assign cmd_err_o   = cmd_err_q;
    assign cmd_idx_o   = cmd_idx_q;
    assign cmd_arg_o   = cmd_arg_q;
    assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_sd_cmd_responder.sv
// Directed bench for sd_cmd_responder: host-side SD clock/CMD driver, a line monitor
// that captures the card's response bits on SD clock rises, and strobe counters.
module tb_sd_cmd_responder;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         sd_clk_i = 1'b1;
    logic         sd_cmd_i = 1'b1;
    logic         sd_cmd_o;
    logic         sd_cmd_oe;
    logic         cmd_valid_o;
    logic         cmd_err_o;
    logic [5:0]   cmd_idx_o;
    logic [31:0]  cmd_arg_o;
    logic         resp_valid_i = 1'b0;
    logic [1:0]   resp_type_i = 2'd0;
    logic [5:0]   resp_idx_i = 6'd0;
    logic [127:0] resp_data_i = '0;
    logic         busy_o;

    sd_cmd_responder #(
        .NCR         (2),
        .SYNC_STAGES (2)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .sd_clk_i     (sd_clk_i),
        .sd_cmd_i     (sd_cmd_i),
        .sd_cmd_o     (sd_cmd_o),
        .sd_cmd_oe    (sd_cmd_oe),
        .cmd_valid_o  (cmd_valid_o),
        .cmd_err_o    (cmd_err_o),
        .cmd_idx_o    (cmd_idx_o),
        .cmd_arg_o    (cmd_arg_o),
        .resp_valid_i (resp_valid_i),
        .resp_type_i  (resp_type_i),
        .resp_idx_i   (resp_idx_i),
        .resp_data_i  (resp_data_i),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_miscmp = 0;

    task automatic check_eq(input string tag, input logic [135:0] got, input logic [135:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference CRC7 (x^7 + x^3 + 1, init 0) over 120 bits, MSB first.
    function automatic logic [6:0] crc7_120(input logic [119:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 119; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    // Line monitor: bits the card drives, sampled where a host would sample them.
    int           sd_rises = 0;
    int           oe_rises = 0;
    int           oe_start_rise = 0;
    logic         oe_prev = 1'b0;
    logic [135:0] line_q = '0;

    always @(posedge sd_clk_i) begin
        sd_rises++;
        if (sd_cmd_oe === 1'b1) begin
            line_q = {line_q[134:0], sd_cmd_o};
            oe_rises++;
            if (!oe_prev) oe_start_rise = sd_rises;
        end
        oe_prev = (sd_cmd_oe === 1'b1);
    end

    int n_valid = 0;
    int n_err = 0;

    always @(negedge clk_i) begin
        if (cmd_valid_o === 1'b1) n_valid++;
        if (cmd_err_o === 1'b1) n_err++;
    end

    // resp_valid_i is driven only here: either an explicit kick, or an armed
    // one-shot that answers the cmd_valid_o strobe in the next cycle.
    logic resp_armed = 1'b0;
    logic resp_kick = 1'b0;

    task automatic tick();
        @(negedge clk_i);
        resp_valid_i = resp_kick || (resp_armed && (cmd_valid_o === 1'b1));
        if (resp_valid_i) resp_armed = 1'b0;
        resp_kick = 1'b0;
    endtask

    // One SD clock period (8 clk_i): host changes CMD on the fall.
    task automatic sd_cycle(input logic b);
        tick();
        sd_clk_i = 1'b0;
        sd_cmd_i = b;
        repeat (3) tick();
        tick();
        sd_clk_i = 1'b1;
        repeat (3) tick();
    endtask

    task automatic idle(input int n);
        repeat (n) sd_cycle(1'b1);
    endtask

    task automatic send_frame(input logic [47:0] f);
        for (int i = 47; i >= 0; i--) sd_cycle(f[i]);
    endtask

    localparam logic [47:0] Cmd0     = 48'h400000000095;
    localparam logic [47:0] Cmd0Bad  = 48'h400000000097;
    localparam logic [47:0] Cmd8     = 48'h48000001AA87;
    localparam logic [47:0] Cmd2     = 48'h42000000004D;
    localparam logic [47:0] Cmd55    = 48'h770000000065;
    localparam logic [127:0] LongData = 128'h00112233_44556677_8899AABB_CCDDEEFF;

    int v0, e0, o0, end_rise;
    logic [47:0] f2;

    initial begin
        // Reset state
        repeat (3) tick();
        rst_i = 1'b0;
        tick();
        check_eq("rst_cmd_o", sd_cmd_o, 1);
        check_eq("rst_oe", sd_cmd_oe, 0);
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_valid", cmd_valid_o, 0);
        check_eq("rst_err", cmd_err_o, 0);
        check_eq("rst_idx", cmd_idx_o, 0);
        check_eq("rst_arg", cmd_arg_o, 0);
        idle(2);

        // CMD0, no response
        v0 = n_valid; o0 = oe_rises;
        resp_type_i = 2'd0; resp_armed = 1'b1;
        send_frame(Cmd0);
        idle(6);
        resp_armed = 1'b0;
        check_eq("cmd0_valid_cnt", n_valid - v0, 1);
        check_eq("cmd0_idx", cmd_idx_o, 0);
        check_eq("cmd0_arg", cmd_arg_o, 0);
        check_eq("cmd0_busy", busy_o, 0);
        check_eq("cmd0_no_drive", oe_rises - o0, 0);

        // CMD8 with short R7 response
        v0 = n_valid; o0 = oe_rises;
        resp_type_i = 2'd1; resp_idx_i = 6'd8; resp_data_i = 128'h1AA; resp_armed = 1'b1;
        send_frame(Cmd8);
        end_rise = sd_rises;
        idle(60);
        resp_armed = 1'b0;
        check_eq("cmd8_valid_cnt", n_valid - v0, 1);
        check_eq("cmd8_idx", cmd_idx_o, 8);
        check_eq("cmd8_arg", cmd_arg_o, 32'h1AA);
        check_eq("r7_line", line_q[47:0], 48'h08000001AA13);
        check_eq("r7_bits", oe_rises - o0, 48);
        check_eq("r7_ncr_gap", oe_start_rise - end_rise, 3);
        check_eq("r7_busy_after", busy_o, 0);
        check_eq("r7_oe_after", sd_cmd_oe, 0);
        check_eq("r7_cmd_after", sd_cmd_o, 1);

        // CMD0 with bad CRC byte
        v0 = n_valid; e0 = n_err;
        send_frame(Cmd0Bad);
        idle(4);
        check_eq("bad_err_cnt", n_err - e0, 1);
        check_eq("bad_valid_cnt", n_valid - v0, 0);
        check_eq("bad_idx_kept", cmd_idx_o, 8);
        check_eq("bad_arg_kept", cmd_arg_o, 32'h1AA);
        check_eq("bad_busy", busy_o, 0);

        // CMD2 with long R2 response
        v0 = n_valid; o0 = oe_rises;
        resp_type_i = 2'd2; resp_data_i = LongData; resp_armed = 1'b1;
        send_frame(Cmd2);
        idle(150);
        resp_armed = 1'b0;
        check_eq("cmd2_idx", cmd_idx_o, 2);
        check_eq("r2_bits", oe_rises - o0, 136);
        check_eq("r2_header", line_q[135:128], 8'h3F);
        check_eq("r2_payload", line_q[127:8], LongData[127:8]);
        check_eq("r2_crc", line_q[7:1], crc7_120(LongData[127:8]));
        check_eq("r2_end", line_q[0], 1);
        check_eq("r2_busy_after", busy_o, 0);

        // Reset during bit 20 of a short response
        o0 = oe_rises;
        resp_type_i = 2'd1; resp_idx_i = 6'd8; resp_data_i = 128'h1AA; resp_armed = 1'b1;
        send_frame(Cmd8);
        for (int k = 0; k < 100; k++) begin
            if (oe_rises - o0 >= 20) break;
            sd_cycle(1'b1);
        end
        resp_armed = 1'b0;
        check_eq("tx_reached_bit20", oe_rises - o0, 20);
        tick();
        sd_clk_i = 1'b0;
        repeat (4) tick();
        check_eq("oe_before_rst", sd_cmd_oe, 1);
        rst_i = 1'b1;
        tick();
        check_eq("rst_tx_oe", sd_cmd_oe, 0);
        check_eq("rst_tx_cmd", sd_cmd_o, 1);
        check_eq("rst_tx_busy", busy_o, 0);
        check_eq("rst_tx_idx", cmd_idx_o, 0);
        rst_i = 1'b0;
        repeat (3) tick();
        sd_clk_i = 1'b1;
        repeat (3) tick();
        idle(4);
        v0 = n_valid; o0 = oe_rises;
        resp_type_i = 2'd0; resp_armed = 1'b1;
        send_frame(Cmd8);
        idle(60);
        resp_armed = 1'b0;
        check_eq("post_rst_valid_cnt", n_valid - v0, 1);
        check_eq("post_rst_idx", cmd_idx_o, 8);
        check_eq("post_rst_arg", cmd_arg_o, 32'h1AA);
        check_eq("post_rst_no_drive", oe_rises - o0, 0);
        check_eq("post_rst_busy", busy_o, 0);

        // New command while waiting for a response; resp_valid_i during RX ignored
        v0 = n_valid; o0 = oe_rises;
        resp_type_i = 2'd1;
        send_frame(Cmd8);
        idle(4);
        check_eq("wait_busy", busy_o, 1);
        f2 = Cmd55;
        for (int i = 47; i >= 0; i--) begin
            if (i == 37) resp_kick = 1'b1;
            sd_cycle(f2[i]);
        end
        idle(4);
        check_eq("second_valid_cnt", n_valid - v0, 2);
        check_eq("second_idx", cmd_idx_o, 6'd55);
        check_eq("second_arg", cmd_arg_o, 0);
        check_eq("second_busy", busy_o, 1);
        resp_type_i = 2'd0;
        resp_kick = 1'b1;
        idle(60);
        check_eq("second_idle", busy_o, 0);
        check_eq("first_resp_never_sent", oe_rises - o0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
